avalon_pkt_limiter: RTL and testbench
=====================================

AVALON_PKT_LIMITER -- requirements
Module: avalon_pkt_limiter

Interface
REQ-001 Parameter MAX_LEN, default 64, meaning maximum beats per packet (SOP through EOP inclusive); legal range 2..65535.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 pkt_in  avalon_st_if.slave  -  stream from the upstream enforcer stage; rdy is driven by this block.
REQ-005 pkt_out  avalon_st_if.master  -  length-limited stream; rdy is driven by the downstream consumer.
REQ-006 too_long_indc  output  1  one-cycle pulse when a packet is truncated.
REQ-007 dropped_beat_indc  output  1  one-cycle pulse per input beat accepted and discarded.

Function
REQ-008 Input accept condition: pkt_in.valid & pkt_in.rdy.
REQ-009 Output transfer condition: pkt_out.valid & pkt_out.rdy.
REQ-010 Output stage is a single register slot holding data, sop, eop, empty and valid; latency from input accept to pkt_out.valid is exactly 1 cycle.
REQ-011 pkt_in.rdy = ~out_slot_valid | pkt_out.rdy in IDLE and PASS; pkt_in.rdy = 1 in DROP.
REQ-012 A held output slot stays stable (all fields unchanged) while pkt_out.valid=1 and pkt_out.rdy=0.
REQ-013 FSM states: IDLE (between packets), PASS (inside a forwarded packet), DROP (discarding the tail of an over-length packet).
REQ-014 IDLE, accepted beat with sop=1 and eop=1: forward the beat; state remains IDLE.
REQ-015 IDLE, accepted beat with sop=1 and eop=0: forward the beat; beat_cnt:=1; go to PASS.
REQ-016 IDLE, accepted beat with sop=0: discard it; pulse dropped_beat_indc; state remains IDLE.
REQ-017 PASS, accepted beat with eop=1 and beat_cnt<MAX_LEN: forward the beat unchanged; go to IDLE.
REQ-018 PASS, accepted beat with eop=0 and beat_cnt=MAX_LEN-1: forward it with eop forced to 1 and empty forced to 0; pulse too_long_indc; go to DROP.
REQ-019 PASS, any other accepted beat: forward it; beat_cnt:=beat_cnt+1.
REQ-020 PASS, accepted beat with sop=1: treat as a data beat; sop is forced to 0 on output.
REQ-021 DROP, every accepted beat: discard it; pulse dropped_beat_indc; go to IDLE when the discarded beat has eop=1.
REQ-022 A packet of exactly MAX_LEN beats passes unmodified and never enters DROP.
REQ-023 beat_cnt width is $clog2(MAX_LEN+1); it never wraps, because PASS always exits at MAX_LEN-1.
REQ-024 Forwarded beats with eop=0 present empty=0 on output.
REQ-025 Input beat and output drain in the same cycle are sustained, so throughput is 1 beat/cycle with pkt_out.rdy held at 1.
REQ-026 too_long_indc and dropped_beat_indc are registered, asserted in the cycle after the triggering accept.

Reset
REQ-027 Asserting rst at any time, including mid-packet, forces: state=IDLE, beat_cnt=0, out slot valid=0, too_long_indc=0, dropped_beat_indc=0.
REQ-028 Output values during reset are pkt_out.valid=0, sop=0, eop=0, data=0, empty=0; pkt_in.rdy=1 (slot empty).
REQ-029 A partial packet interrupted by reset is lost; no EOP is synthesized for it.
REQ-030 After reset deassertion, the block waits in IDLE for an SOP.

Structure
REQ-031 The state enum (IDLE, PASS, DROP) lives in shared package avalon_pkg alongside the existing stream typedefs.
REQ-032 MAX_LEN stays a module parameter and does not go in the package.
REQ-033 The output register slot is implemented as sub-module avalon_out_reg (valid/ready single-entry register), reusable by other stages.
REQ-034 The FSM, beat_cnt and indications live in the top module.

Verification
REQ-035 MAX_LEN=4, pkt_out.rdy=1, 3-beat packet -> 3 identical beats out, 1 cycle later, sop on beat 1 and eop on beat 3, no indications.
REQ-036 MAX_LEN=4, 7-beat packet with empty=2 on eop -> 4 beats out with eop=1 and empty=0 on beat 4; too_long_indc pulses once; dropped_beat_indc pulses 3 times; next packet is forwarded normally.
REQ-037 MAX_LEN=4, exactly 4-beat packet -> forwarded unmodified; too_long_indc stays 0.
REQ-038 pkt_out.rdy toggling 1,0,0,1 during a 3-beat packet -> no beat lost or duplicated; held slot stable; pkt_in.rdy=0 while the slot is full and pkt_out.rdy=0.
REQ-039 Valid beat with sop=0 in IDLE -> no output; dropped_beat_indc pulses once.
REQ-040 rst asserted after beat 2 of a 5-beat packet -> all outputs 0 immediately; following single-beat sop+eop packet forwarded with sop=eop=1.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared Avalon-ST stream types plus the packet limiter state encoding.
package avalon_pkg;

  localparam int DATA_W  = 32;
  localparam int EMPTY_W = 2;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [EMPTY_W-1:0] empty_t;

  typedef struct packed {
    data_t  data;
    logic   sop;
    logic   eop;
    empty_t empty;
  } beat_t;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } lim_state_t;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST beat bundle; master drives the beat, slave drives rdy.
interface avalon_st_if;
  import avalon_pkg::*;

  logic   valid;
  logic   rdy;
  data_t  data;
  logic   sop;
  logic   eop;
  empty_t empty;

  modport master (output valid, data, sop, eop, empty, input rdy);
  modport slave  (input valid, data, sop, eop, empty, output rdy);

endinterface

// File: rtl/avalon_out_reg.sv
// Single-entry valid/ready register slot; 1 cycle latency.
// Accepts when empty or draining the same cycle; holds its beat stable while out_rdy=0.
module avalon_out_reg
  import avalon_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  beat_t in_beat,
  output logic  in_rdy,
  output logic  out_valid,
  output beat_t out_beat,
  input  logic  out_rdy
);

  assign in_rdy = ~out_valid | out_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_rdy) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_beat <= in_beat;
      end
    end
  end

endmodule

// File: rtl/avalon_pkt_limiter.sv
// Truncates packets longer than MAX_LEN beats and discards stray/tail beats; 1 cycle latency.
// Backpressure follows the output slot, except while discarding a tail, when input is always ready.
module avalon_pkt_limiter
  import avalon_pkg::*;
#(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  avalon_st_if.slave  pkt_in,
  avalon_st_if.master pkt_out,
  output logic        too_long_indc,
  output logic        dropped_beat_indc
);

  localparam int unsigned      CNT_W    = $clog2(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LEN - 1);

  lim_state_t       state, state_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic             too_long_nxt, dropped_nxt;
  logic             accept, fwd_vld, slot_rdy, out_vld;
  beat_t            in_beat, fwd_beat, out_beat;

  assign in_beat    = '{data: pkt_in.data, sop: pkt_in.sop, eop: pkt_in.eop, empty: pkt_in.empty};
  assign pkt_in.rdy = slot_rdy | (state == DROP);
  assign accept     = pkt_in.valid & pkt_in.rdy;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    too_long_nxt = 1'b0;
    dropped_nxt  = 1'b0;
    fwd_vld      = 1'b0;
    fwd_beat     = in_beat;
    if (!in_beat.eop) begin
      fwd_beat.empty = '0;
    end
    case (state)
      IDLE: begin
        if (accept) begin
          if (in_beat.sop) begin
            fwd_vld = 1'b1;
            if (!in_beat.eop) begin
              beat_cnt_nxt = CNT_W'(1);
              state_nxt    = PASS;
            end
          end else begin
            dropped_nxt = 1'b1;
          end
        end
      end
      PASS: begin
        if (accept) begin
          fwd_vld      = 1'b1;
          fwd_beat.sop = 1'b0;
          if (in_beat.eop) begin
            beat_cnt_nxt = '0;
            state_nxt    = IDLE;
          end else if (beat_cnt == LAST_CNT) begin
            // Close the packet here; the rest of it is discarded.
            fwd_beat.eop   = 1'b1;
            fwd_beat.empty = '0;
            too_long_nxt   = 1'b1;
            beat_cnt_nxt   = '0;
            state_nxt      = DROP;
          end else begin
            beat_cnt_nxt = beat_cnt + CNT_W'(1);
          end
        end
      end
      DROP: begin
        if (accept) begin
          dropped_nxt = 1'b1;
          if (in_beat.eop) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt    = IDLE;
        beat_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      beat_cnt          <= '0;
      too_long_indc     <= 1'b0;
      dropped_beat_indc <= 1'b0;
    end else begin
      state             <= state_nxt;
      beat_cnt          <= beat_cnt_nxt;
      too_long_indc     <= too_long_nxt;
      dropped_beat_indc <= dropped_nxt;
    end
  end

  avalon_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (fwd_vld),
    .in_beat   (fwd_beat),
    .in_rdy    (slot_rdy),
    .out_valid (out_vld),
    .out_beat  (out_beat),
    .out_rdy   (pkt_out.rdy)
  );

  assign pkt_out.valid = out_vld;
  assign pkt_out.data  = out_beat.data;
  assign pkt_out.sop   = out_beat.sop;
  assign pkt_out.eop   = out_beat.eop;
  assign pkt_out.empty = out_beat.empty;

endmodule

// File: tb/tb_avalon_pkt_limiter.sv
// Randomized and directed bench for avalon_pkt_limiter with a packet-level reference model.
module tb_avalon_pkt_limiter;
  import avalon_pkg::*;

  localparam int MAX_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if pkt_in ();
  avalon_st_if pkt_out ();
  logic too_long_indc, dropped_beat_indc;

  avalon_pkt_limiter #(.MAX_LEN(MAX_LEN)) dut (
    .clk               (clk),
    .rst               (rst),
    .pkt_in            (pkt_in),
    .pkt_out           (pkt_out),
    .too_long_indc     (too_long_indc),
    .dropped_beat_indc (dropped_beat_indc)
  );

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  beat_t obs_q[$];
  int    too_cnt, drop_cnt, exp_too, exp_drop;
  int    hold_viol, rdy_viol, stall_seen;
  bit    chk_rdy = 1'b0;
  int    rdy_mode = 0;
  logic  rdy_man = 1'b1;
  beat_t held;
  bit    held_vld = 1'b0;
  beat_t mon_beat;

  assign mon_beat = '{data: pkt_out.data, sop: pkt_out.sop, eop: pkt_out.eop, empty: pkt_out.empty};

  // Downstream ready: 0 = always ready, 1 = random, 2 = driven by the running test.
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       pkt_out.rdy = 1'b1;
      1:       pkt_out.rdy = ($urandom_range(0, 3) != 0);
      default: pkt_out.rdy = rdy_man;
    endcase
  end

  // Recorder: collects transferred beats, indication pulses and handshake violations.
  always @(negedge clk) begin
    if (!rst) begin
      held_vld = 1'b0;
    end else begin
      if (pkt_out.valid && pkt_out.rdy) obs_q.push_back(mon_beat);
      if (held_vld && (!pkt_out.valid || mon_beat !== held)) hold_viol++;
      held_vld = pkt_out.valid && !pkt_out.rdy;
      held     = mon_beat;
      if (chk_rdy && pkt_out.valid && !pkt_out.rdy) begin
        stall_seen++;
        if (pkt_in.rdy !== 1'b0) rdy_viol++;
      end
      if (too_long_indc) too_cnt++;
      if (dropped_beat_indc) drop_cnt++;
    end
  end

  task automatic clear_sb();
    exp_q.delete();
    obs_q.delete();
    too_cnt = 0; drop_cnt = 0; exp_too = 0; exp_drop = 0;
    hold_viol = 0; rdy_viol = 0; stall_seen = 0;
  endtask

  // Entered and left at posedge+1.
  task automatic send_beat(input beat_t b);
    int n = 0;
    pkt_in.valid = 1'b1;
    pkt_in.data  = b.data;
    pkt_in.sop   = b.sop;
    pkt_in.eop   = b.eop;
    pkt_in.empty = b.empty;
    do begin
      @(negedge clk);
      n++;
    end while (pkt_in.rdy !== 1'b1 && n < 300);
    if (pkt_in.rdy !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_timeout: pkt_in.rdy=%b after %0d cycles, required 1", pkt_in.rdy, n);
    end
    @(posedge clk); #1;
    pkt_in.valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: first MAX_LEN beats of a packet are forwarded (sop only on beat 0,
  // eop/empty of a truncated packet forced on beat MAX_LEN-1); the remainder is dropped.
  task automatic send_pkt(input int len, input bit mid_sop, input int gap_max);
    beat_t b, e;
    for (int i = 0; i < len; i++) begin
      b.data  = $urandom;
      b.sop   = (i == 0) ? 1'b1 : (mid_sop ? 1'($urandom_range(0, 1)) : 1'b0);
      b.eop   = (i == len - 1);
      b.empty = 2'($urandom_range(0, 3));
      if (i < MAX_LEN) begin
        e = b;
        e.sop = (i == 0);
        if (len > MAX_LEN && i == MAX_LEN - 1) begin
          e.eop = 1'b1;
          e.empty = '0;
        end else if (!b.eop) begin
          e.empty = '0;
        end
        exp_q.push_back(e);
      end else begin
        exp_drop++;
      end
      send_beat(b);
      if (gap_max > 0) idle($urandom_range(0, gap_max));
    end
    if (len > MAX_LEN) exp_too++;
  endtask

  task automatic send_stray();
    beat_t b;
    b.data  = $urandom;
    b.sop   = 1'b0;
    b.eop   = 1'($urandom_range(0, 1));
    b.empty = 2'($urandom_range(0, 3));
    exp_drop++;
    send_beat(b);
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (obs_q.size() >= exp_q.size() && !pkt_out.valid) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pkt_in.valid = 1'b0;
    repeat (3) @(negedge clk);
    checks += 7;
    if (pkt_out.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", pkt_out.valid); end
    if (pkt_out.sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b, required 0", pkt_out.sop); end
    if (pkt_out.eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b, required 0", pkt_out.eop); end
    if (pkt_out.data !== '0) begin errors++; $display("FAIL reset_data: got %h, required 0", pkt_out.data); end
    if (pkt_out.empty !== '0) begin errors++; $display("FAIL reset_empty: got %h, required 0", pkt_out.empty); end
    if (pkt_in.rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b, required 1", pkt_in.rdy); end
    if ({too_long_indc, dropped_beat_indc} !== 2'b00) begin
      errors++; $display("FAIL reset_indc: got %b, required 00", {too_long_indc, dropped_beat_indc});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    idle(1);
  endtask

  task automatic test_short_pkt();
    clear_sb();
    send_pkt(3, 1'b0, 0);
    wait_drain();
    checks += 3;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL short_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    if (too_cnt != 0) begin errors++; $display("FAIL short_too_long: got %0d pulses, required 0", too_cnt); end
    if (drop_cnt != 0) begin errors++; $display("FAIL short_dropped: got %0d pulses, required 0", drop_cnt); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL short_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_truncate();
    clear_sb();
    send_pkt(7, 1'b0, 0);
    send_pkt(3, 1'b0, 0);
    wait_drain();
    checks += 3;
    if (obs_q.size() != 7) begin errors++; $display("FAIL trunc_count: got %0d beats, required 7", obs_q.size()); end
    if (too_cnt != 1) begin errors++; $display("FAIL trunc_too_long: got %0d pulses, required 1", too_cnt); end
    if (drop_cnt != 3) begin errors++; $display("FAIL trunc_dropped: got %0d pulses, required 3", drop_cnt); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL trunc_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_exact_len();
    clear_sb();
    send_pkt(MAX_LEN, 1'b0, 1);
    wait_drain();
    checks += 3;
    if (obs_q.size() != MAX_LEN) begin errors++; $display("FAIL exact_count: got %0d beats, required %0d", obs_q.size(), MAX_LEN); end
    if (too_cnt != 0) begin errors++; $display("FAIL exact_too_long: got %0d pulses, required 0", too_cnt); end
    if (drop_cnt != 0) begin errors++; $display("FAIL exact_dropped: got %0d pulses, required 0", drop_cnt); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL exact_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_backpressure();
    bit pat[8] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    clear_sb();
    rdy_man  = 1'b1;
    rdy_mode = 2;
    chk_rdy  = 1'b1;
    fork
      send_pkt(3, 1'b0, 0);
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1;
        rdy_man = pat[k];
      end
    join
    wait_drain();
    chk_rdy  = 1'b0;
    rdy_mode = 0;
    checks += 4;
    if (obs_q.size() != 3) begin errors++; $display("FAIL bp_count: got %0d beats, required 3", obs_q.size()); end
    if (stall_seen == 0) begin errors++; $display("FAIL bp_stall: got %0d stalled cycles, required >0", stall_seen); end
    if (rdy_viol != 0) begin errors++; $display("FAIL bp_in_rdy: got %0d cycles with rdy=1 while full, required 0", rdy_viol); end
    if (hold_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d unstable held cycles, required 0", hold_viol); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_no_sop();
    clear_sb();
    send_stray();
    checks++;
    if (dropped_beat_indc !== 1'b1) begin errors++; $display("FAIL nosop_pulse: got %b, required 1", dropped_beat_indc); end
    wait_drain();
    checks += 2;
    if (obs_q.size() != 0) begin errors++; $display("FAIL nosop_out: got %0d beats, required 0", obs_q.size()); end
    if (drop_cnt != 1) begin errors++; $display("FAIL nosop_dropped: got %0d pulses, required 1", drop_cnt); end
  endtask

  task automatic test_mid_reset();
    beat_t b;
    clear_sb();
    b = '{data: 32'hA5A5_0001, sop: 1'b1, eop: 1'b0, empty: 2'd0};
    send_beat(b);
    b = '{data: 32'hA5A5_0002, sop: 1'b0, eop: 1'b0, empty: 2'd0};
    send_beat(b);
    rst = 1'b0;
    #1;
    checks += 3;
    if (pkt_out.valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b, required 0", pkt_out.valid); end
    if (mon_beat !== '0) begin errors++; $display("FAIL mrst_beat: got %h, required 0", mon_beat); end
    if ({too_long_indc, dropped_beat_indc} !== 2'b00) begin
      errors++; $display("FAIL mrst_indc: got %b, required 00", {too_long_indc, dropped_beat_indc});
    end
    idle(2);
    rst = 1'b1;
    clear_sb();
    idle(1);
    b = '{data: 32'h0BAD_CAFE, sop: 1'b1, eop: 1'b1, empty: 2'd3};
    exp_q.push_back(b);
    send_beat(b);
    checks++;
    if (pkt_out.valid !== 1'b1 || mon_beat !== b) begin
      errors++; $display("FAIL mrst_latency: got valid=%b beat=%h, required valid=1 beat=%h", pkt_out.valid, mon_beat, b);
    end
    wait_drain();
    checks += 2;
    if (obs_q.size() != 1) begin errors++; $display("FAIL mrst_count: got %0d beats, required 1", obs_q.size()); end
    else if (obs_q[0] !== b) begin errors++; $display("FAIL mrst_beat_out: got %h, required %h", obs_q[0], b); end
    if (drop_cnt != 0) begin errors++; $display("FAIL mrst_dropped: got %0d pulses, required 0", drop_cnt); end
  endtask

  task automatic test_random();
    clear_sb();
    rdy_mode = 1;
    for (int p = 0; p < 60; p++) begin
      if ($urandom_range(0, 4) == 0) send_stray();
      else send_pkt($urandom_range(1, 9), 1'b1, $urandom_range(0, 2));
    end
    rdy_mode = 0;
    wait_drain();
    checks += 4;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    if (too_cnt != exp_too) begin errors++; $display("FAIL rand_too_long: got %0d pulses, required %0d", too_cnt, exp_too); end
    if (drop_cnt != exp_drop) begin errors++; $display("FAIL rand_dropped: got %0d pulses, required %0d", drop_cnt, exp_drop); end
    if (hold_viol != 0) begin errors++; $display("FAIL rand_hold: got %0d unstable held cycles, required 0", hold_viol); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_beat%0d: got %h, required %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    pkt_in.valid = 1'b0;
    pkt_in.data  = '0;
    pkt_in.sop   = 1'b0;
    pkt_in.eop   = 1'b0;
    pkt_in.empty = '0;
    pkt_out.rdy  = 1'b1;
    clear_sb();
    test_reset();
    test_short_pkt();
    test_truncate();
    test_exact_len();
    test_backpressure();
    test_no_sop();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
